flappy_vga_renderer: RTL and testbench

- Next-generation Flappy VGA pixel renderer with built-in 640x480 sync generation.
- Draws one bird and NUM_PIPES pipe pairs from live game-logic coordinates.
- Coordinates are latched into shadow registers once per frame to prevent tearing; the colour datapath is a two-stage pipeline with syncs delay-matched.
- Sits between the game-state logic and the board VGA pins.

---
 rtl/flappy_vga_pkg.sv | 44 ++++
 rtl/flappy_vga_timing.sv | 81 ++++++++
 rtl/flappy_vga_renderer.sv | 246 ++++++++++++++++++++++++
 tb/tb_flappy_vga_renderer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_vga_pkg.sv
// Shared timing constants, colour codes and colour helper for the Flappy VGA renderer.
// Optional ground band is enabled by defining FLAPPY_GROUND_EN (see flappy_vga_renderer).
package flappy_vga_pkg;

    // 640x480 @ 60 Hz raster timing, in pixel ticks and lines
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_TOTAL = 800;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_TOTAL = 525;

    // Shadow registers reload at H=0 of the first non-visible line
    localparam int LATCH_LINE = V_VIS;

    typedef enum logic [1:0] {
        SKY    = 2'd0,
        PIPE   = 2'd1,
        BIRD   = 2'd2,
        GROUND = 2'd3
    } colour_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    // Map a colour code to the 1-bit-per-channel pin pattern
    function automatic rgb_t colour_to_rgb(input colour_t colour);
        rgb_t rgb;
        case (colour)
            SKY:     rgb = '{r: 1'b0, g: 1'b0, b: 1'b1};
            PIPE:    rgb = '{r: 1'b0, g: 1'b1, b: 1'b0};
            BIRD:    rgb = '{r: 1'b1, g: 1'b0, b: 1'b0};
            GROUND:  rgb = '{r: 1'b1, g: 1'b1, b: 1'b0};
            default: rgb = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/flappy_vga_timing.sv
// Raster position counters with sync, visible-area and shadow-latch decode.
// Timing defaults come from flappy_vga_pkg; the parameters allow a reduced raster.
module flappy_vga_timing
    import flappy_vga_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int H_VIS_PX   = H_VIS,
    parameter int H_FP_PX    = H_FP,
    parameter int H_SYNC_PX  = H_SYNC,
    parameter int H_TOTAL_PX = H_TOTAL,
    parameter int V_VIS_LN   = V_VIS,
    parameter int V_FP_LN    = V_FP,
    parameter int V_SYNC_LN  = V_SYNC,
    parameter int V_TOTAL_LN = V_TOTAL,
    parameter int LATCH_LN   = LATCH_LINE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [COORD_W-1:0] h_pos,
    output logic [COORD_W-1:0] v_pos,
    output logic               h_sync,
    output logic               v_sync,
    output logic               visible,
    output logic               at_latch
);

    localparam logic [COORD_W-1:0] ONE          = COORD_W'(1);
    localparam logic [COORD_W-1:0] ZERO         = COORD_W'(0);
    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL_PX - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL_LN - 1);
    localparam logic [COORD_W-1:0] H_VIS_END    = COORD_W'(H_VIS_PX);
    localparam logic [COORD_W-1:0] V_VIS_END    = COORD_W'(V_VIS_LN);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_VIS_PX + H_FP_PX);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_VIS_PX + H_FP_PX + H_SYNC_PX);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_VIS_LN + V_FP_LN);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_VIS_LN + V_FP_LN + V_SYNC_LN);
    localparam logic [COORD_W-1:0] LATCH_V      = COORD_W'(LATCH_LN);

    logic [COORD_W-1:0] h_cnt_r;
    logic [COORD_W-1:0] v_cnt_r;
    logic               h_sync_s;
    logic               v_sync_s;
    logic               visible_s;
    logic               at_latch_s;

    // Advance the raster position once per pixel strobe; V steps when H wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_r <= ZERO;
            v_cnt_r <= ZERO;
        end else if (pix_en) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= ZERO;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= ZERO;
                end else begin
                    v_cnt_r <= v_cnt_r + ONE;
                end
            end else begin
                h_cnt_r <= h_cnt_r + ONE;
            end
        end
    end

    // Decode active-low syncs, the visible window and the shadow-latch point
    always_comb begin
        h_sync_s   = !((h_cnt_r >= H_SYNC_START) && (h_cnt_r < H_SYNC_END));
        v_sync_s   = !((v_cnt_r >= V_SYNC_START) && (v_cnt_r < V_SYNC_END));
        visible_s  = (h_cnt_r < H_VIS_END) && (v_cnt_r < V_VIS_END);
        at_latch_s = (h_cnt_r == ZERO) && (v_cnt_r == LATCH_V);
    end

    assign h_pos    = h_cnt_r;
    assign v_pos    = v_cnt_r;
    assign h_sync   = h_sync_s;
    assign v_sync   = v_sync_s;
    assign visible  = visible_s;
    assign at_latch = at_latch_s;

endmodule

// File: rtl/flappy_vga_renderer.sv
// Flappy VGA renderer: per-frame shadow latch of bird/pipe coordinates, a two-stage
// colour pipeline (hit flags, then priority colour select) and delay-matched syncs.
// Optional feature: define FLAPPY_GROUND_EN to draw a ground band of GROUND_H rows.
module flappy_vga_renderer
    import flappy_vga_pkg::*;
#(
    parameter int NUM_PIPES  = 4,
    parameter int COORD_W    = 10,
    parameter int PIPE_W     = 80,
    parameter int GAP_H      = 100,
    parameter int BIRD_HALF  = 10,
    parameter int GROUND_H   = 40,
    parameter int H_VIS_PX   = H_VIS,
    parameter int H_FP_PX    = H_FP,
    parameter int H_SYNC_PX  = H_SYNC,
    parameter int H_TOTAL_PX = H_TOTAL,
    parameter int V_VIS_LN   = V_VIS,
    parameter int V_FP_LN    = V_FP,
    parameter int V_SYNC_LN  = V_SYNC,
    parameter int V_TOTAL_LN = V_TOTAL
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pix_en,
    input  logic signed [COORD_W-1:0]      bird_x,
    input  logic signed [COORD_W-1:0]      bird_y,
    input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
    input  logic [NUM_PIPES*COORD_W-1:0]   pipe_gap_y,
    input  logic [NUM_PIPES-1:0]           pipe_valid,
    output logic                           frame_start,
    output logic                           vga_h_sync,
    output logic                           vga_v_sync,
    output logic                           vga_r,
    output logic                           vga_g,
    output logic                           vga_b
);

`ifdef FLAPPY_GROUND_EN
    localparam logic GROUND_EN = 1'b1;
`else
    localparam logic GROUND_EN = 1'b0;
`endif

    // Bird distances are signed with two guard bits so off-screen centres never wrap
    localparam int                 SW         = COORD_W + 2;
    localparam logic [SW-1:0]      HALF       = SW'(BIRD_HALF);
    localparam logic [COORD_W-1:0] GROUND_ROW = COORD_W'(V_VIS_LN - GROUND_H);

    logic [COORD_W-1:0] h_pos_s;
    logic [COORD_W-1:0] v_pos_s;
    logic               h_sync_s;
    logic               v_sync_s;
    logic               visible_s;
    logic               at_latch_s;
    logic               latch_s;

    flappy_vga_timing #(
        .COORD_W    (COORD_W),
        .H_VIS_PX   (H_VIS_PX),
        .H_FP_PX    (H_FP_PX),
        .H_SYNC_PX  (H_SYNC_PX),
        .H_TOTAL_PX (H_TOTAL_PX),
        .V_VIS_LN   (V_VIS_LN),
        .V_FP_LN    (V_FP_LN),
        .V_SYNC_LN  (V_SYNC_LN),
        .V_TOTAL_LN (V_TOTAL_LN),
        .LATCH_LN   (V_VIS_LN)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .pix_en   (pix_en),
        .h_pos    (h_pos_s),
        .v_pos    (v_pos_s),
        .h_sync   (h_sync_s),
        .v_sync   (v_sync_s),
        .visible  (visible_s),
        .at_latch (at_latch_s)
    );

    assign latch_s = pix_en & at_latch_s;

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    logic signed [COORD_W-1:0]    bird_x_r;
    logic signed [COORD_W-1:0]    bird_y_r;
    logic [NUM_PIPES*COORD_W-1:0] pipe_x_r;
    logic [NUM_PIPES*COORD_W-1:0] pipe_gap_y_r;
    logic [NUM_PIPES-1:0]         pipe_valid_r;
    logic                         frame_start_r;

    // Copy live coordinates once per frame so a frame never mixes two game states
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bird_x_r      <= '0;
            bird_y_r      <= '0;
            pipe_x_r      <= '0;
            pipe_gap_y_r  <= '0;
            pipe_valid_r  <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= latch_s;
            if (latch_s) begin
                bird_x_r     <= bird_x;
                bird_y_r     <= bird_y;
                pipe_x_r     <= pipe_x;
                pipe_gap_y_r <= pipe_gap_y;
                pipe_valid_r <= pipe_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit detection for the current raster position
    // ------------------------------------------------------------------
    logic signed [SW-1:0] dx_s;
    logic signed [SW-1:0] dy_s;
    logic [SW-1:0]        adx_s;
    logic [SW-1:0]        ady_s;
    logic                 bird_hit_s;
    logic [NUM_PIPES-1:0] pipe_hit_s;
    logic                 ground_hit_s;

    // Bird box test: |H-bx| and |V-by| both within the half-size
    always_comb begin
        dx_s = $signed({2'b00, h_pos_s}) - $signed({{2{bird_x_r[COORD_W-1]}}, bird_x_r});
        dy_s = $signed({2'b00, v_pos_s}) - $signed({{2{bird_y_r[COORD_W-1]}}, bird_y_r});
        if (dx_s[SW-1]) begin
            adx_s = $unsigned(-dx_s);
        end else begin
            adx_s = $unsigned(dx_s);
        end
        if (dy_s[SW-1]) begin
            ady_s = $unsigned(-dy_s);
        end else begin
            ady_s = $unsigned(dy_s);
        end
        bird_hit_s = (adx_s <= HALF) && (ady_s <= HALF);
    end

    // One comparator per pipe pair; one extra bit keeps edge sums from wrapping
    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        logic [COORD_W:0] h_s;
        logic [COORD_W:0] v_s;
        logic [COORD_W:0] px_s;
        logic [COORD_W:0] px_end_s;
        logic [COORD_W:0] gy_s;
        logic [COORD_W:0] gy_end_s;

        assign h_s      = {1'b0, h_pos_s};
        assign v_s      = {1'b0, v_pos_s};
        assign px_s     = {1'b0, pipe_x_r[i*COORD_W +: COORD_W]};
        assign gy_s     = {1'b0, pipe_gap_y_r[i*COORD_W +: COORD_W]};
        assign px_end_s = px_s + (COORD_W+1)'(PIPE_W);
        assign gy_end_s = gy_s + (COORD_W+1)'(GAP_H);

        assign pipe_hit_s[i] = pipe_valid_r[i]
                             && (h_s >= px_s) && (h_s < px_end_s)
                             && ((v_s < gy_s) || (v_s >= gy_end_s));
    end

    assign ground_hit_s = GROUND_EN & (v_pos_s >= GROUND_ROW);

    // ------------------------------------------------------------------
    // Stage 1: registered hit flags with syncs and visible flag alongside
    // ------------------------------------------------------------------
    logic bird_hit_r;
    logic pipe_hit_r;
    logic ground_hit_r;
    logic visible_r;
    logic h_sync_d1_r;
    logic v_sync_d1_r;

    // Capture hit flags for this pixel and delay syncs by one tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bird_hit_r   <= 1'b0;
            pipe_hit_r   <= 1'b0;
            ground_hit_r <= 1'b0;
            visible_r    <= 1'b0;
            h_sync_d1_r  <= 1'b1;
            v_sync_d1_r  <= 1'b1;
        end else if (pix_en) begin
            bird_hit_r   <= bird_hit_s;
            pipe_hit_r   <= |pipe_hit_s;
            ground_hit_r <= ground_hit_s;
            visible_r    <= visible_s;
            h_sync_d1_r  <= h_sync_s;
            v_sync_d1_r  <= v_sync_s;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority colour select and output registers
    // ------------------------------------------------------------------
    colour_t colour_s;
    rgb_t    rgb_s;
    rgb_t    rgb_r;
    logic    h_sync_d2_r;
    logic    v_sync_d2_r;

    // Bird beats ground, ground beats pipes, sky fills the rest
    always_comb begin
        colour_s = SKY;
        if (bird_hit_r) begin
            colour_s = BIRD;
        end else if (ground_hit_r) begin
            colour_s = GROUND;
        end else if (pipe_hit_r) begin
            colour_s = PIPE;
        end else begin
            colour_s = SKY;
        end
    end

    // Blank all colour channels outside the visible window
    always_comb begin
        rgb_s = '0;
        if (visible_r) begin
            rgb_s = colour_to_rgb(colour_s);
        end else begin
            rgb_s = '0;
        end
    end

    // Register the pin values; syncs get their second delay tick here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_r       <= '0;
            h_sync_d2_r <= 1'b1;
            v_sync_d2_r <= 1'b1;
        end else if (pix_en) begin
            rgb_r       <= rgb_s;
            h_sync_d2_r <= h_sync_d1_r;
            v_sync_d2_r <= v_sync_d1_r;
        end
    end

    assign frame_start = frame_start_r;
    assign vga_h_sync  = h_sync_d2_r;
    assign vga_v_sync  = v_sync_d2_r;
    assign vga_r       = rgb_r.r;
    assign vga_g       = rgb_r.g;
    assign vga_b       = rgb_r.b;

endmodule

// File: tb/tb_flappy_vga_renderer.sv
// Scoreboard bench for flappy_vga_renderer on a reduced 80x56 raster (64x48 visible).
// The stimulus process pushes expected pin values per clock; the monitor pops and compares.
`timescale 1ns/1ps
module tb_flappy_vga_renderer;

    localparam int NP  = 2;
    localparam int CW  = 10;
    localparam int PW  = 8;
    localparam int GH  = 10;
    localparam int BH  = 3;
    localparam int GRH = 8;
    localparam int HV  = 64;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HT  = 80;
    localparam int VV  = 48;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VT  = 56;
    localparam int FRAME = HT * VT;
    localparam int VIS_PIX = HV * VV;
    localparam logic [4:0] OUT_RST = 5'b11000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   pix_en;
    logic signed [CW-1:0]   bird_x;
    logic signed [CW-1:0]   bird_y;
    logic [NP*CW-1:0]       pipe_x;
    logic [NP*CW-1:0]       pipe_gap_y;
    logic [NP-1:0]          pipe_valid;
    logic                   frame_start;
    logic                   vga_h_sync;
    logic                   vga_v_sync;
    logic                   vga_r;
    logic                   vga_g;
    logic                   vga_b;

    flappy_vga_renderer #(
        .NUM_PIPES(NP), .COORD_W(CW), .PIPE_W(PW), .GAP_H(GH), .BIRD_HALF(BH), .GROUND_H(GRH),
        .H_VIS_PX(HV), .H_FP_PX(HFP), .H_SYNC_PX(HS), .H_TOTAL_PX(HT),
        .V_VIS_LN(VV), .V_FP_LN(VFP), .V_SYNC_LN(VS), .V_TOTAL_LN(VT)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .bird_x(bird_x), .bird_y(bird_y),
        .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .pipe_valid(pipe_valid),
        .frame_start(frame_start), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [5:0] mon_act;
    int cnt_r, cnt_g, cnt_b, cnt_hs, cnt_vs, cnt_fs;

    // reference model state: raster position, shadow copy, two output stages
    int         mh, mv;
    int         sbx, sby;
    int         spx[NP];
    int         sgy[NP];
    bit         sval[NP];
    logic [4:0] s1, s2;

    // expected {hs, vs, r, g, b} for one raster position using the shadow copy
    function automatic logic [4:0] expect_px(input int h, input int v);
        logic hs, vs, vis, bird, pipe, ground;
        logic [2:0] rgb;
        hs   = !((h >= HV + HFP) && (h < HV + HFP + HS));
        vs   = !((v >= VV + VFP) && (v < VV + VFP + VS));
        vis  = (h < HV) && (v < VV);
        bird = (h - sbx <= BH) && (sbx - h <= BH) && (v - sby <= BH) && (sby - v <= BH);
        pipe = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (sval[p] && (h >= spx[p]) && (h < spx[p] + PW) && ((v < sgy[p]) || (v >= sgy[p] + GH)))
                pipe = 1'b1;
        end
        ground = 1'b0;
`ifdef FLAPPY_GROUND_EN
        ground = (v >= VV - GRH);
`endif
        if (!vis)        rgb = 3'b000;
        else if (bird)   rgb = 3'b100;
        else if (ground) rgb = 3'b110;
        else if (pipe)   rgb = 3'b010;
        else             rgb = 3'b001;
        return {hs, vs, rgb};
    endfunction

    task automatic clear_model();
        mh = 0; mv = 0; s1 = OUT_RST; s2 = OUT_RST;
        sbx = 0; sby = 0;
        for (int p = 0; p < NP; p++) begin spx[p] = 0; sgy[p] = 0; sval[p] = 1'b0; end
    endtask

    task automatic latch_shadow();
        sbx = $signed(bird_x);
        sby = $signed(bird_y);
        for (int p = 0; p < NP; p++) begin
            spx[p]  = int'(pipe_x[p*CW +: CW]);
            sgy[p]  = int'(pipe_gap_y[p*CW +: CW]);
            sval[p] = pipe_valid[p];
        end
    endtask

    // one clock: predict the pins after the coming edge, push it, then let the edge pass
    task automatic tick();
        logic fs;
        @(negedge clk);
        fs = 1'b0;
        if (pix_en) begin
            fs = (mh == 0) && (mv == VV);
            s2 = s1;
            s1 = expect_px(mh, mv);
            if (fs) latch_shadow();
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        exp_q.push_back({fs, s2});
        @(posedge clk);
        #2;
    endtask

    task automatic set_bird(input int x, input int y);
        bird_x = CW'(x);
        bird_y = CW'(y);
    endtask

    task automatic set_pipe(input int p, input int x, input int gy, input bit v);
        pipe_x[p*CW +: CW]     = CW'(x);
        pipe_gap_y[p*CW +: CW] = CW'(gy);
        pipe_valid[p]          = v;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // one full frame of ticks starting at H=0,V=0; optionally move the bird mid-frame
    task automatic run_frame(input int mid_line, input int new_bx);
        cnt_r = 0; cnt_g = 0; cnt_b = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if ((mid_line >= 0) && (i == mid_line * HT)) bird_x = CW'(new_bx);
            tick();
        end
    endtask

    task automatic check_frame(input string name, input int red, input int green);
        check_int({name, "_red"}, cnt_r, red);
`ifndef FLAPPY_GROUND_EN
        check_int({name, "_green"}, cnt_g, green);
        check_int({name, "_blue"}, cnt_b, VIS_PIX - red - green);
`endif
        check_int({name, "_frame_start"}, cnt_fs, 1);
    endtask

    // monitor: compare every presented output against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {frame_start, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_errors++;
                $display("FAIL pixel t=%0t fs/hs/vs/rgb got %b required %b", $time, mon_act, mon_exp);
            end
            cnt_r  += int'(vga_r);
            cnt_g  += int'(vga_g);
            cnt_b  += int'(vga_b);
            cnt_hs += int'(!vga_h_sync);
            cnt_vs += int'(!vga_v_sync);
            cnt_fs += int'(frame_start);
        end
    end

    initial begin
        reset = 1'b0; pix_en = 1'b0;
        bird_x = '0; bird_y = '0; pipe_x = '0; pipe_gap_y = '0; pipe_valid = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_outputs", int'({frame_start, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b}), int'(6'b011000));
        @(posedge clk);
        #2;
        set_bird(32, 24);
        reset = 1'b1;
        pix_en = 1'b1;

        // frame 0 still shows the cleared shadow; bird (32,24) latches at its end
        run_frame(-1, 0);

        // frame 1: bird only; also sync widths and one frame_start per frame
        set_pipe(0, 10, 20, 1'b1);
        run_frame(-1, 0);
        check_frame("f1_bird", 49, 0);
        check_int("f1_hsync_low", cnt_hs, HS * VT);
        check_int("f1_vsync_low", cnt_vs, VS * HT);

        // frame 2: bird + pipe0; bird_x moved at line 10 must not tear this frame
        run_frame(10, 5);
        check_frame("f2_pipe0", 49, 304);

        // frame 3: moved bird (5,24) with pipe0
        set_bird(-2, -2);
        set_pipe(0, 10, 20, 1'b0);
        set_pipe(1, 60, 40, 1'b1);
        run_frame(-1, 0);
        check_frame("f3_moved", 49, 304);

        // frame 4: bird clipped at the top-left corner, pipe1 clipped at the right edge
        set_bird(61, 5);
        run_frame(-1, 0);
        check_frame("f4_clip", 4, 160);

        // frame 5: bird overlapping the clipped pipe wins the overlap
        run_frame(-1, 0);
        check_frame("f5_overlap", 42, 132);

        // pixel strobe low holds everything, then a mid-frame reset
        for (int i = 0; i < 800; i++) tick();
        pix_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        pix_en = 1'b1;
        for (int i = 0; i < 400; i++) tick();
        reset = 1'b0;
        #1;
        check_int("reset_midframe", int'({frame_start, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b}), int'(6'b011000));
        repeat (2) @(posedge clk);
        #2;
        clear_model();
        reset = 1'b1;

        // after reset the cleared shadow puts the bird at the origin
        run_frame(-1, 0);
        check_frame("post_reset", 16, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
